// File: rtl/dtmr_pkg.sv
// Shared types and constants for the triplicated scrubbing register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dtmr_pkg;

    localparam int NUM_REPL = 3;

    typedef logic [1:0] repl_idx_t;

    localparam repl_idx_t INJ_NONE = 2'd3;

endpackage

// File: rtl/dtmr_voter.sv
// Bitwise 2-of-3 majority voter.
// Latency: combinational.
// Backpressure: none.
module dtmr_voter #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/dtmr_reg_scrub.sv
// Triplicated register with voted output, scrubbing, fault injection and failure tracking.
// Latency: d to q one edge; err/mism combinational from the replicas.
// Backpressure: none; a load is accepted on every edge with en=1.
module dtmr_reg_scrub
    import dtmr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               SCRUB_EN    = 1,
    parameter int               CNT_W       = 4,
    parameter int               PERSIST_THR = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             inj_en,
    input  logic [1:0]       inj_sel,
    input  logic [WIDTH-1:0] inj_mask,
    output logic [WIDTH-1:0] q,
    output logic             err,
    output logic [2:0]       mism,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [2:0]       fail
);

    localparam logic [3:0]       THR     = 4'(PERSIST_THR);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_REPL-1:0][WIDTH-1:0] repl;
    logic [NUM_REPL-1:0][WIDTH-1:0] repl_next;
    logic [NUM_REPL-1:0][WIDTH-1:0] stage1;
    logic [NUM_REPL-1:0][3:0]       pcnt;
    logic [WIDTH-1:0]               v;

    // Three identical first-stage voters so a single voter upset cannot reach q.
    for (genvar g = 0; g < NUM_REPL; g++) begin : g_stage1
        dtmr_voter #(.WIDTH(WIDTH)) u_voter (
            .a (repl[0]),
            .b (repl[1]),
            .c (repl[2]),
            .y (stage1[g])
        );
    end

    dtmr_voter #(.WIDTH(WIDTH)) u_voter_final (
        .a (stage1[0]),
        .b (stage1[1]),
        .c (stage1[2]),
        .y (q)
    );

    assign v   = stage1[0];
    assign err = |mism;

    always_comb begin
        repl_next = repl;
        mism      = '0;
        for (int i = 0; i < NUM_REPL; i++) begin
            repl_next[i] = en ? d : ((SCRUB_EN != 0) ? v : repl[i]);
            if (inj_en && (inj_sel != INJ_NONE) && (inj_sel == repl_idx_t'(i)))
                repl_next[i] = repl_next[i] ^ inj_mask;
            mism[i] = |(repl[i] ^ v);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            repl     <= {NUM_REPL{RESET_VAL}};
            corr_cnt <= '0;
            pcnt     <= '0;
            fail     <= '0;
        end else begin
            repl <= repl_next;
            if (err && (corr_cnt != CNT_MAX))
                corr_cnt <= corr_cnt + 1'b1;
            for (int i = 0; i < NUM_REPL; i++) begin
                if (mism[i]) begin
                    if (pcnt[i] < THR)
                        pcnt[i] <= pcnt[i] + 4'd1;
                    // Compare against THR-1 so a threshold of 15 cannot wrap the sum.
                    if (pcnt[i] >= (THR - 4'd1))
                        fail[i] <= 1'b1;
                end else begin
                    pcnt[i] <= 4'd0;
                end
            end
        end
    end

endmodule

// File: doc/dtmr_reg_scrub.md
DTMR_REG_SCRUB -- requirements
Module: dtmr_reg_scrub

Interface
REQ-001 Parameter WIDTH, default 8, data width of each replica register.
REQ-002 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into all replicas on reset.
REQ-003 Parameter SCRUB_EN, default 1; 1 means idle replicas reload the voted value, 0 means they hold their own value.
REQ-004 Parameter CNT_W, default 4, width of the correction counter.
REQ-005 Parameter PERSIST_THR, default 3, number of consecutive mismatch cycles that declares a replica failed; legal range 1..15.
REQ-006 The block SHALL have one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 en  in  1  load d into all replicas at the next edge.
REQ-010 d  in  WIDTH  write data.
REQ-011 inj_en  in  1  fault-injection strobe.
REQ-012 inj_sel  in  2  target replica 0..2; value 3 means no injection.
REQ-013 inj_mask  in  WIDTH  bits XORed into the target replica's next value.
REQ-014 q  out  WIDTH  DTMR-voted output.
REQ-015 err  out  1  any replica disagrees with the vote (combinational).
REQ-016 mism  out  3  per-replica disagreement flags (combinational).
REQ-017 corr_cnt  out  CNT_W  saturating count of cycles with err=1.
REQ-018 fail  out  3  sticky per-replica failure flags.

Function
REQ-019 Each replica r0, r1, r2 SHALL be a WIDTH-bit register.
REQ-020 Replica next value: rN_next = en ? d : (SCRUB_EN ? v : rN).
REQ-021 v SHALL be the bitwise 2-of-3 majority of r0, r1, r2.
REQ-022 When inj_en=1 and inj_sel=N (N<3), replica N SHALL load rN_next XOR inj_mask; the other replicas are unaffected.
REQ-023 q SHALL be the final majority of three independent first-stage voters, each voting over r0, r1, r2; latency from d (en=1) to q is one clock edge.
REQ-024 mism[N] = |(rN XOR v); err = |mism; both combinational from the current registers.
REQ-025 corr_cnt SHALL increment by 1 at each edge where err=1, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-026 Each replica has a persistence counter (4 bits): it increments while mism[N]=1, saturating at PERSIST_THR, and clears to 0 at any edge where mism[N]=0.
REQ-027 fail[N] SHALL set at the edge where the persistence counter reaches PERSIST_THR, and SHALL stay set until reset.
REQ-028 With SCRUB_EN=1 and no further injection, a single-replica upset SHALL be corrected at the next edge: err returns to 0 one cycle after it asserts.
REQ-029 When en=1 and injection occur in the same cycle, the injection SHALL apply on top of d.
REQ-030 When err=1 and en=1 in the same cycle, the counter SHALL still increment, and replicas load d.

Reset
REQ-031 At an edge with rst_n=0: r0=r1=r2=RESET_VAL, corr_cnt=0, persistence counters=0, fail=0.
REQ-032 After that reset edge, q=RESET_VAL, err=0, mism=0.
REQ-033 Reset SHALL override en and injection.
REQ-034 Reset asserted mid-operation SHALL clear sticky fail flags and any pending mismatch at that edge.

Structure
REQ-035 Package dtmr_pkg SHALL hold the replica index type (0..2), the constant NUM_REPL=3, and the constant INJ_NONE=2'd3.
REQ-036 Sub-module dtmr_voter SHALL be a WIDTH-bit bitwise 2-of-3 majority voter.
REQ-037 dtmr_voter SHALL be instantiated four times: three first-stage voters and one final voter.
REQ-038 The mismatch logic SHALL use first-stage voter 0's output as v.

Verification (WIDTH=8, CNT_W=4, PERSIST_THR=3)
REQ-039 Reset, then en=1, d=0xA5 for one edge -> q=0xA5, err=0, corr_cnt=0.
REQ-040 Hold en=0, then inject inj_sel=1, inj_mask=0x01 for one edge -> q=0xA5, mism=3'b010, err=1; next edge err=0, corr_cnt=1.
REQ-041 Inject inj_sel=2, inj_mask=0x80 on 3 consecutive edges -> fail=3'b100 after the third mismatch cycle; fail stays set after injection stops.
REQ-042 20 spaced single injections -> corr_cnt stops at 15.
REQ-043 With SCRUB_EN=0, inject replica 0 with inj_mask=0xFF -> err stays 1 while en=0; then en=1, d=0x3C -> q=0x3C, err=0.
REQ-044 Assert rst_n=0 while fail=3'b100 and err=1 -> next edge fail=0, corr_cnt=0, q=0x00.
